// File: rtl/contador_pkg.sv
// Shared types and helpers for the step-counter run controller.
package contador_pkg;

  // Controller states: waiting for a command, sweeping, or frozen mid-sweep.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  // Number of distinct counter values visited in one lap.
  function automatic int unsigned values_per_lap(input int unsigned count_from,
                                                 input int unsigned count_to,
                                                 input int unsigned step);
    return (count_to - count_from) / step + 1;
  endfunction

endpackage

// File: rtl/contador_sequencer_step_counter.sv
// Counter datapath: sweeps COUNT_FROM..COUNT_TO in STEP increments and
// flags the last value of a lap so the sequencer can count laps.
module step_counter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COUNT_FROM = 0,
  parameter int unsigned COUNT_TO   = 95,
  parameter int unsigned STEP       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  last
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]      sum;

  // One extra bit so out+STEP past the top of the range never wraps silently.
  assign sum  = {1'b0, cnt_q} + SUM_W'(STEP);
  assign last = (sum > SUM_W'(COUNT_TO));
  assign out  = cnt_q;

  // Next value: clear wins, otherwise step or wrap back to the lap start.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = DATA_WIDTH'(COUNT_FROM);
    end else if (en) begin
      cnt_d = last ? DATA_WIDTH'(COUNT_FROM) : sum[DATA_WIDTH-1:0];
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      cnt_q <= DATA_WIDTH'(COUNT_FROM);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/contador_sequencer.sv
// Run controller for the step counter: takes "run N laps" commands, drives
// the counter's enable/clear, handles pause/abort and reports lap progress.
module contador_sequencer
  import contador_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COUNT_FROM = 0,
  parameter int unsigned COUNT_TO   = 95,
  parameter int unsigned STEP       = 1,
  parameter int unsigned LAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [LAP_WIDTH-1:0]  cmd_laps,
  output logic                  cmd_ready,
  input  logic                  pause,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] out,
  output logic [LAP_WIDTH-1:0]  lap,
  output logic                  busy,
  output logic                  done
);

  // Reject parameter sets that cannot describe a valid sweep.
  if (COUNT_FROM > COUNT_TO) begin : g_bad_range
    $error("contador_sequencer: COUNT_FROM must not exceed COUNT_TO");
  end
  if (STEP == 0) begin : g_bad_step
    $error("contador_sequencer: STEP must be at least 1");
  end
  if (64'(COUNT_TO) >= (64'd1 << DATA_WIDTH)) begin : g_bad_width
    $error("contador_sequencer: COUNT_TO does not fit in DATA_WIDTH bits");
  end

  seq_state_t           state_q, state_d;
  logic [LAP_WIDTH-1:0] lap_q, lap_d;
  logic [LAP_WIDTH-1:0] target_q, target_d;
  logic [LAP_WIDTH-1:0] lap_inc;
  logic                 done_q, done_d;
  logic                 cnt_en, cnt_clr, cnt_last;

  step_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .COUNT_FROM (COUNT_FROM),
    .COUNT_TO   (COUNT_TO),
    .STEP       (STEP)
  ) u_step_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .out  (out),
    .last (cnt_last)
  );

  // lap_q stays below target_q while running, so the increment cannot overflow.
  assign lap_inc   = lap_q + LAP_WIDTH'(1);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign lap       = lap_q;
  assign done      = done_q;

  // Next state, lap/target updates and counter control; abort beats pause beats advance.
  always_comb begin
    state_d  = state_q;
    lap_d    = lap_q;
    target_d = target_q;
    done_d   = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          lap_d = '0;
          if (cmd_laps != '0) begin
            state_d  = RUN;
            target_d = cmd_laps;
            cnt_clr  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            lap_d = lap_inc;
            if (lap_inc == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
              cnt_clr = 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lap_q    <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lap_q    <= lap_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_contador_sequencer.sv
// Self-checking bench: two sequencer instances (default sweep and a coarse
// 0..10 step 3 sweep) checked every cycle against a lap/position model.
module tb_contador_sequencer;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int A_FROM = 0, A_TO = 95, A_STEP = 1;
  localparam int B_FROM = 0, B_TO = 10, B_STEP = 3;
  localparam int A_V = (A_TO - A_FROM) / A_STEP + 1;
  localparam int B_V = (B_TO - B_FROM) / B_STEP + 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          a_valid = 1'b0, a_pause = 1'b0, a_abort = 1'b0;
  logic [LW-1:0] a_laps  = '0;
  logic          a_ready, a_busy, a_done;
  logic [DW-1:0] a_out;
  logic [LW-1:0] a_lap;

  logic          b_valid = 1'b0, b_pause = 1'b0, b_abort = 1'b0;
  logic [LW-1:0] b_laps  = '0;
  logic          b_ready, b_busy, b_done;
  logic [DW-1:0] b_out;
  logic [LW-1:0] b_lap;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  contador_sequencer u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_laps(a_laps), .cmd_ready(a_ready),
    .pause(a_pause), .abort(a_abort), .out(a_out), .lap(a_lap), .busy(a_busy), .done(a_done)
  );

  contador_sequencer #(
    .DATA_WIDTH(DW), .COUNT_FROM(B_FROM), .COUNT_TO(B_TO), .STEP(B_STEP), .LAP_WIDTH(LW)
  ) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_laps(b_laps), .cmd_ready(b_ready),
    .pause(b_pause), .abort(b_abort), .out(b_out), .lap(b_lap), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position index within the lap, laps done, run target.
  typedef struct {
    int mode;
    int pos;
    int lap;
    int target;
    bit done;
  } mdl_t;

  function automatic mdl_t mdl_next(input mdl_t m, input bit valid, input int laps,
                                    input bit pause, input bit abort, input int v);
    mdl_t n;
    n = m;
    n.done = 1'b0;
    if (m.mode == M_IDLE) begin
      if (valid) begin
        n.lap = 0;
        n.pos = 0;
        if (laps == 0) n.done = 1'b1;
        else begin
          n.mode   = M_RUN;
          n.target = laps;
        end
      end
    end else if (abort) begin
      n.mode = M_IDLE;
      n.pos  = 0;
    end else if (m.mode == M_PAUSE) begin
      if (!pause) n.mode = M_RUN;
    end else if (pause) begin
      n.mode = M_PAUSE;
    end else if (m.pos == v - 1) begin
      n.pos = 0;
      n.lap = m.lap + 1;
      if (n.lap == m.target) begin
        n.mode = M_IDLE;
        n.done = 1'b1;
      end
    end else begin
      n.pos = m.pos + 1;
    end
    return n;
  endfunction

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= mdl_next(ma, a_valid, int'(a_laps), a_pause, a_abort, A_V);
      mb <= mdl_next(mb, b_valid, int'(b_laps), b_pause, b_abort, B_V);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_out",   a_out,   64'(A_FROM + ma.pos * A_STEP));
      check("a_lap",   a_lap,   64'(ma.lap));
      check("a_done",  a_done,  64'(ma.done));
      check("a_busy",  a_busy,  64'(ma.mode != M_IDLE));
      check("a_ready", a_ready, 64'(ma.mode == M_IDLE));
      check("b_out",   b_out,   64'(B_FROM + mb.pos * B_STEP));
      check("b_lap",   b_lap,   64'(mb.lap));
      check("b_done",  b_done,  64'(mb.done));
      check("b_busy",  b_busy,  64'(mb.mode != M_IDLE));
      check("b_ready", b_ready, 64'(mb.mode == M_IDLE));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int done_at;
  int done_cnt;
  int exp_b [4] = '{3, 6, 9, 0};

  initial begin
    #2 rst = 1'b0;
    #1 cmp_en = 1'b1;
    #19 rst = 1'b1;
    tick();

    // Reset state
    check("rst_out", a_out, 0);
    check("rst_lap", a_lap, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ready", a_ready, 1);

    // 1: two laps, done 192 edges after accept
    a_valid = 1'b1; a_laps = 8'd2;
    tick();
    a_valid = 1'b0;
    check("t1_busy", a_busy, 1);
    check("t1_out0", a_out, 0);
    done_at = -1; done_cnt = 0;
    for (int k = 1; k <= 250; k++) begin
      tick();
      if (k == 95) check("t1_out95", a_out, 95);
      if (k == 96) begin
        check("t1_wrap_out", a_out, 0);
        check("t1_wrap_lap", a_lap, 1);
      end
      if (a_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    check("t1_done_edge", 64'(done_at), 192);
    check("t1_done_pulses", 64'(done_cnt), 1);
    check("t1_lap", a_lap, 2);
    check("t1_out_end", a_out, 0);

    // 2: one lap with pause sampled on 9 edges -> out frozen for 10 edges
    a_valid = 1'b1; a_laps = 8'd1;
    tick();
    a_valid = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 50) begin
        check("t2_out_pre", a_out, 50);
        a_pause = 1'b1;
      end
      if (k == 59) a_pause = 1'b0;
      if (k == 60) check("t2_out_frozen", a_out, 50);
      if (k == 61) check("t2_out_resume", a_out, 51);
      if (a_done && done_at < 0) done_at = k;
    end
    check("t2_done_edge", 64'(done_at), 106);

    // 3: abort sampled at edge 50 of a three-lap run
    a_valid = 1'b1; a_laps = 8'd3;
    tick();
    a_valid = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 50) a_abort = 1'b1;
      tick();
      if (k == 49) check("t3_out_pre", a_out, 49);
    end
    a_abort = 1'b0;
    check("t3_busy", a_busy, 0);
    check("t3_out", a_out, 0);
    check("t3_lap", a_lap, 0);
    check("t3_ready", a_ready, 1);
    check("t3_done", a_done, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (a_done) done_cnt++;
    end
    check("t3_no_done", 64'(done_cnt), 0);

    // 4: coarse sweep 0,3,6,9 on instance B, three laps
    b_valid = 1'b1; b_laps = 8'd3;
    tick();
    b_valid = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 4) check("t4_out_seq", b_out, 64'(exp_b[k-1]));
      if (b_done && done_at < 0) done_at = k;
    end
    check("t4_done_edge", 64'(done_at), 12);
    check("t4_lap", b_lap, 3);

    // 5: asynchronous reset between edges mid-run
    a_valid = 1'b1; a_laps = 8'd2;
    tick();
    a_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("t5_out_pre", a_out, 20);
    #2 rst = 1'b0;
    #1;
    check("t5_out", a_out, 0);
    check("t5_busy", a_busy, 0);
    check("t5_ready", a_ready, 1);
    check("t5_lap", a_lap, 0);
    #3 rst = 1'b1;
    tick();
    check("t5_idle_after", a_busy, 0);

    // 6: zero-lap command, then commands ignored during a run
    a_valid = 1'b1; a_laps = 8'd0;
    tick();
    a_valid = 1'b0;
    check("t6_done", a_done, 1);
    check("t6_busy", a_busy, 0);
    check("t6_lap", a_lap, 0);
    tick();
    check("t6_done_drop", a_done, 0);
    a_valid = 1'b1; a_laps = 8'd1;
    tick();
    a_valid = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 150; k++) begin
      if (k == 10) begin a_valid = 1'b1; a_laps = 8'd5; end
      if (k == 13) a_valid = 1'b0;
      tick();
      if (k == 10) check("t6_ready_run", a_ready, 0);
      if (a_done && done_at < 0) done_at = k;
    end
    check("t6_done_edge", 64'(done_at), 96);
    check("t6_lap_final", a_lap, 1);

    // Randomized traffic on both instances, checked by the model every cycle
    fork
      begin
        for (int i = 0; i < 2500; i++) begin
          a_valid = ($urandom_range(0, 19) == 0);
          a_laps  = LW'($urandom_range(0, 2));
          if ($urandom_range(0, 15) == 0) a_pause = ~a_pause;
          a_abort = ($urandom_range(0, 199) == 0);
          tick();
        end
      end
      begin
        for (int i = 0; i < 2500; i++) begin
          b_valid = ($urandom_range(0, 3) == 0);
          b_laps  = LW'($urandom_range(0, 5));
          if ($urandom_range(0, 7) == 0) b_pause = ~b_pause;
          b_abort = ($urandom_range(0, 49) == 0);
          tick();
        end
      end
    join
    a_valid = 1'b0; a_pause = 1'b0; a_abort = 1'b0;
    b_valid = 1'b0; b_pause = 1'b0; b_abort = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
